// File: rtl/frame_avg_line_reader.sv
// Reads one line from the two newest completed RAM banks, averages them per sample and streams SYNC, tag, samples, checksum.
// Each sample costs RD_LAT+2 clocks; out_valid/out_data hold until accepted, and out_ready may stay low indefinitely.
module frame_avg_line_reader #(
  parameter int         SAMPLES = 512,
  parameter int         ADDR_W  = 9,
  parameter int         RD_LAT  = 2,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              frame_done,
  input  logic [7:0]        line_tag,
  input  logic              xfer_req,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W+1:0] rd_addr_a,
  output logic [ADDR_W+1:0] rd_addr_b,
  input  logic [7:0]        rd_data_a,
  input  logic [7:0]        rd_data_b,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  output logic              req_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_TAG,
    S_RD,
    S_WAIT,
    S_OUT,
    S_CSUM
  } state_t;

  localparam int              LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        frames_done;
  logic [7:0]        last_tag;
  logic [1:0]        bank_a;
  logic [1:0]        bank_b;
  logic [7:0]        tag_q;
  logic [ADDR_W-1:0] idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic [7:0]        csum;
  logic              fd_seen;
  logic              accept;
  logic [7:0]        avg;

  assign accept = xfer_req && (state == S_IDLE) && (frames_done == 2'd2);
  assign busy   = (state != S_IDLE);

  // Round-half-up average; the 9-bit sum is shifted before truncation so it cannot overflow.
  assign avg = 8'(({1'b0, rd_data_a} + {1'b0, rd_data_b} + 9'd1) >> 1);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SYNC;
      end
      S_SYNC: begin
        out_valid = 1'b1;
        out_data  = SYNC;
        if (out_ready) state_nxt = S_TAG;
      end
      S_TAG: begin
        out_valid = 1'b1;
        out_data  = tag_q;
        if (out_ready) state_nxt = S_RD;
      end
      S_RD: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == '0) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = avg;
        if (out_ready) state_nxt = (idx == LAST_IDX) ? S_CSUM : S_RD;
      end
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        out_last  = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      wr_bank     <= 2'd0;
      frames_done <= 2'd0;
      last_tag    <= 8'd0;
      bank_a      <= 2'd0;
      bank_b      <= 2'd0;
      tag_q       <= 8'd0;
      idx         <= '0;
      lat_cnt     <= '0;
      csum        <= 8'd0;
      fd_seen     <= 1'b0;
      overrun     <= 1'b0;
      req_drop    <= 1'b0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
    end else begin
      req_drop <= xfer_req && !accept;

      if (frame_done) begin
        wr_bank  <= wr_bank + 2'd1;
        last_tag <= line_tag;
        if (frames_done != 2'd2) frames_done <= frames_done + 2'd1;
      end

      // Banks lock from the pre-increment pointer even when frame_done coincides.
      if (accept) begin
        bank_a  <= wr_bank - 2'd1;
        bank_b  <= wr_bank - 2'd2;
        tag_q   <= last_tag;
        csum    <= last_tag;
        idx     <= '0;
        overrun <= 1'b0;
        fd_seen <= frame_done;
      end else if (frame_done && busy) begin
        // The second writer advance in one packet lands on bank_b.
        if (fd_seen) overrun <= 1'b1;
        fd_seen <= 1'b1;
      end

      case (state)
        S_RD: begin
          rd_addr_a <= {bank_a, idx};
          rd_addr_b <= {bank_b, idx};
          lat_cnt   <= LAT_LOAD;
        end
        S_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            csum <= csum + avg;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_avg_line_reader.sv
// Randomised bench for frame_avg_line_reader with a two-port pipelined RAM model and a packet-level reference.
module tb_frame_avg_line_reader;

  localparam int SAMPLES = 512;
  localparam int PKT_LEN = SAMPLES + 3;

  logic        clk_50M = 1'b0;
  logic        reset = 1'b1;
  logic        frame_done = 1'b0;
  logic [7:0]  line_tag = 8'd0;
  logic        xfer_req = 1'b0;
  logic [1:0]  wr_bank;
  logic [10:0] rd_addr_a, rd_addr_b;
  logic [10:0] addr_qa, addr_qb;
  logic [7:0]  rd_data_a, rd_data_b;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last, busy, overrun, req_drop;

  logic [7:0]  mem [0:2047];

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model state
  logic [1:0]  m_wr = 2'd0;
  int          m_frames = 0;
  logic [7:0]  m_tag = 8'd0;
  logic        m_busy = 1'b0;
  logic        m_ovr = 1'b0;
  int          m_fdp = 0;
  logic [1:0]  exp_ba = 2'd0, exp_bb = 2'd0;
  logic [7:0]  exp_q[$];

  logic [7:0]  rx_q[$];
  logic        rx_last[$];
  logic        mon_en = 1'b0;
  logic        hold_vld = 1'b0;
  logic [7:0]  hold_dat = 8'd0;
  int          rdy_mode = 0;

  frame_avg_line_reader dut (
    .clk_50M   (clk_50M),
    .reset     (reset),
    .frame_done(frame_done),
    .line_tag  (line_tag),
    .xfer_req  (xfer_req),
    .wr_bank   (wr_bank),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun),
    .req_drop  (req_drop)
  );

  initial forever #10 clk_50M = ~clk_50M;

  // RAM: address register then output register
  always @(posedge clk_50M) begin
    addr_qa   <= rd_addr_a;
    addr_qb   <= rd_addr_b;
    rd_data_a <= mem[addr_qa];
    rd_data_b <= mem[addr_qb];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  initial forever begin
    @(posedge clk_50M);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Stream monitor: collects accepted bytes and checks hold-while-stalled.
  initial forever begin
    @(negedge clk_50M);
    if (mon_en) begin
      if (hold_vld) begin
        chk("hold_vld", 32'(out_valid), 32'd1);
        chk("hold_dat", 32'(out_data), 32'(hold_dat));
      end
      if (out_valid && out_ready) begin
        if (rx_q.size() >= 2 && rx_q.size() < SAMPLES + 2) begin
          chk("addr_a", 32'(rd_addr_a), 32'({exp_ba, 9'(rx_q.size() - 2)}));
          chk("addr_b", 32'(rd_addr_b), 32'({exp_bb, 9'(rx_q.size() - 2)}));
        end
        rx_q.push_back(out_data);
        rx_last.push_back(out_last);
        hold_vld = 1'b0;
      end else if (out_valid) begin
        hold_vld = 1'b1;
        hold_dat = out_data;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  task automatic build_expected();
    int s;
    int a;
    int b;
    int v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(m_tag);
    s = int'(m_tag);
    for (int i = 0; i < SAMPLES; i++) begin
      a = int'(mem[int'(exp_ba) * SAMPLES + i]);
      b = int'(mem[int'(exp_bb) * SAMPLES + i]);
      v = (a + b + 1) / 2;
      exp_q.push_back(8'(v));
      s += v;
    end
    exp_q.push_back(8'(s % 256));
  endtask

  task automatic cycle_in(input logic fd, input logic [7:0] tag, input logic req);
    logic acc;
    acc = req && !m_busy && (m_frames == 2);
    if (acc) begin
      exp_ba = m_wr - 2'd1;
      exp_bb = m_wr - 2'd2;
      build_expected();
      m_busy = 1'b1;
      m_ovr  = 1'b0;
      m_fdp  = 0;
    end
    if (fd) begin
      if (m_busy) begin
        m_fdp++;
        if (m_fdp >= 2) m_ovr = 1'b1;
      end
      m_wr = m_wr + 2'd1;
      if (m_frames < 2) m_frames++;
      m_tag = tag;
    end
    frame_done = fd;
    line_tag   = tag;
    xfer_req   = req;
    tick();
    frame_done = 1'b0;
    xfer_req   = 1'b0;
    if (m_busy && rx_q.size() == PKT_LEN) m_busy = 1'b0;
    if (req) chk("req_drop", 32'(req_drop), 32'(!acc));
    chk("wr_bank", 32'(wr_bank), 32'(m_wr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (!m_busy) chk("idle_vld", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_pkt();
    for (int n = 0; n < 20000 && m_busy; n++) cycle_in(1'b0, 8'd0, 1'b0);
    if (m_busy) begin
      chk("pkt_timeout", 32'd0, 32'd1);
      m_busy = 1'b0;
    end
  endtask

  task automatic wait_rx(input int cnt);
    for (int n = 0; n < 20000 && rx_q.size() < cnt; n++) cycle_in(1'b0, 8'd0, 1'b0);
    if (rx_q.size() < cnt) chk("rx_timeout", 32'(rx_q.size()), 32'(cnt));
  endtask

  task automatic cmp_pkt();
    chk("pkt_len", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) begin
        chk("byte", 32'(rx_q[i]), 32'(exp_q[i]));
        chk("last", 32'(rx_last[i]), 32'(i == exp_q.size() - 1));
      end
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_last.delete();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    tick();
    reset    = 1'b0;
    hold_vld = 1'b0;
    clear_rx();
    m_wr = 2'd0; m_frames = 0; m_tag = 8'd0; m_busy = 1'b0; m_ovr = 1'b0; m_fdp = 0;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrb", 32'(wr_bank), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    mon_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    repeat (3) tick();
    chk("r_vld", 32'(out_valid), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_wrb", 32'(wr_bank), 32'd0);
    chk("r_addra", 32'(rd_addr_a), 32'd0);
    chk("r_addrb", 32'(rd_addr_b), 32'd0);
    chk("r_ovr", 32'(overrun), 32'd0);
    chk("r_drop", 32'(req_drop), 32'd0);
    chk("r_last", 32'(out_last), 32'd0);
    chk("r_data", 32'(out_data), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // constant banks, one frame is not enough, then a clean packet
    for (int i = 0; i < SAMPLES; i++) begin
      mem[i] = 8'd10;
      mem[SAMPLES + i] = 8'd20;
    end
    cycle_in(1'b1, 8'd7, 1'b0);
    cycle_in(1'b0, 8'd0, 1'b1);
    repeat (3) cycle_in(1'b0, 8'd0, 1'b0);
    cycle_in(1'b1, 8'd9, 1'b0);
    cycle_in(1'b0, 8'd0, 1'b1);
    wait_pkt();
    cmp_pkt();
    if (rx_q.size() == PKT_LEN) begin
      chk("p1_sync", 32'(rx_q[0]), 32'h A5);
      chk("p1_tag", 32'(rx_q[1]), 32'h09);
      chk("p1_s0", 32'(rx_q[2]), 32'h0F);
      chk("p1_csum", 32'(rx_q[PKT_LEN - 1]), 32'h09);
    end
    chk("p1_wrb", 32'(wr_bank), 32'd2);
    clear_rx();

    // random data, rounding corners, random ready with a long stall
    for (int i = 0; i < 2 * SAMPLES; i++) mem[i] = 8'($urandom);
    mem[SAMPLES + 0] = 8'd255; mem[0] = 8'd255;
    mem[SAMPLES + 1] = 8'd0;   mem[1] = 8'd1;
    mem[SAMPLES + 2] = 8'd100; mem[2] = 8'd103;
    rdy_mode = 1;
    cycle_in(1'b0, 8'd0, 1'b1);
    cycle_in(1'b0, 8'd0, 1'b1);
    wait_rx(100);
    rdy_mode = 2;
    repeat (50) cycle_in(1'b0, 8'd0, 1'b0);
    rdy_mode = 1;
    wait_pkt();
    cmp_pkt();
    if (rx_q.size() == PKT_LEN) begin
      chk("avg_ff", 32'(rx_q[2]), 32'hFF);
      chk("avg_01", 32'(rx_q[3]), 32'h01);
      chk("avg_66", 32'(rx_q[4]), 32'h66);
    end
    clear_rx();

    // two writer advances inside one packet
    rdy_mode = 0;
    cycle_in(1'b0, 8'd0, 1'b1);
    repeat (10) cycle_in(1'b0, 8'd0, 1'b0);
    cycle_in(1'b1, 8'($urandom), 1'b0);
    repeat (10) cycle_in(1'b0, 8'd0, 1'b0);
    cycle_in(1'b1, 8'($urandom), 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_pkt();
    cmp_pkt();
    chk("ovr_hold", 32'(overrun), 32'd1);
    clear_rx();

    // request coincident with frame_done, then reset mid-packet
    rdy_mode = 1;
    cycle_in(1'b1, 8'($urandom), 1'b1);
    chk("ovr_clr", 32'(overrun), 32'd0);
    wait_rx(202);
    do_reset();
    rdy_mode = 0;
    cycle_in(1'b0, 8'd0, 1'b1);
    cycle_in(1'b1, 8'($urandom), 1'b0);
    cycle_in(1'b0, 8'd0, 1'b1);
    cycle_in(1'b1, 8'($urandom), 1'b0);
    cycle_in(1'b0, 8'd0, 1'b1);
    wait_pkt();
    cmp_pkt();
    clear_rx();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
